// File: rtl/vout_guard.sv
// Video output guard: pipelines PPU syncs/pixels to the HDMI transmitter and blanks
// pixel data until the incoming timing has been stable. Optional stats: VOUT_GUARD_STATS_EN.
module vout_guard #(
  parameter int COLOR_WIDTH   = 8,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                     HDMI_CLK_w,
  input  logic                     HDMI_nRST_w,
  input  logic                     VSYNC_i,
  input  logic                     HSYNC_i,
  input  logic                     DE_i,
  input  logic [3*COLOR_WIDTH-1:0] VD_i,
  input  logic                     force_mute_i,
  output logic                     VSYNC_o,
  output logic                     HSYNC_o,
  output logic                     DE_o,
  output logic [3*COLOR_WIDTH-1:0] VD_o,
  output logic                     locked_o,
  output logic [11:0]              h_total_o,
  output logic [11:0]              v_total_o,
  output logic [7:0]               unlock_cnt_o
);
  localparam int VW = 3*COLOR_WIDTH;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  state_t          state_q, state_d;
  logic            vs1_q, hs1_q, de1_q;
  logic [VW-1:0]   vd1_q;
  logic            vs_prev_q, hs_prev_q;
  logic            vs_o_q, hs_o_q, de_o_q;
  logic [VW-1:0]   vd_o_q;
  logic            fm_meta_q, fm_s_q, fm_prev_q;
  logic            mute_q, mute_d;
  logic [11:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, v_meas;
  logic [11:0]     ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic [3:0]      match_q, match_d;
  logic            hs_rise, vs_rise, h_sat, h_match, v_match, fm_rise;

  assign hs_rise = hs1_q & ~hs_prev_q;
  assign vs_rise = vs1_q & ~vs_prev_q;
  assign h_sat   = &h_cnt_q;
  assign fm_rise = fm_s_q & ~fm_prev_q;
  // A line whose HSYNC edge coincides with VSYNC still belongs to the ending frame.
  assign v_meas  = (hs_rise && !(&v_cnt_q)) ? v_cnt_q + 12'd1 : v_cnt_q;
  assign h_cnt_d = hs_rise ? 12'd1 : (h_sat ? h_cnt_q : h_cnt_q + 12'd1);
  assign v_cnt_d = vs_rise ? 12'd0 : v_meas;
  assign h_match = (h_cnt_q == ref_h_q);
  assign v_match = (v_meas == ref_v_q);

  always_comb begin
    state_d = state_q;
    ref_h_d = ref_h_q;
    ref_v_d = ref_v_q;
    match_d = match_q;
    if (h_sat) begin
      state_d = UNLOCKED;
    end else begin
      case (state_q)
        UNLOCKED: if (vs_rise) begin
          ref_h_d = h_cnt_q;
          ref_v_d = v_meas;
          match_d = 4'd0;
          state_d = LOCKING;
        end
        LOCKING: if (vs_rise) begin
          if (h_match && v_match) begin
            match_d = match_q + 4'd1;
            if (match_d == 4'(STABLE_FRAMES)) state_d = LOCKED;
          end else begin
            ref_h_d = h_cnt_q;
            ref_v_d = v_meas;
            match_d = 4'd0;
          end
        end
        LOCKED: if ((hs_rise && !h_match) || (vs_rise && !v_match)) state_d = UNLOCKED;
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // Mute drops only at a frame boundary so the sink never sees a partial frame.
  always_comb begin
    mute_d = mute_q;
    if (vs_rise && state_q == LOCKED && !fm_s_q) mute_d = 1'b0;
    if ((state_q == LOCKED && state_d != LOCKED) || fm_rise) mute_d = 1'b1;
  end

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      vs1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      vd1_q     <= '0;
      vs_prev_q <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_o_q    <= 1'b0;
      hs_o_q    <= 1'b0;
      de_o_q    <= 1'b0;
      vd_o_q    <= '0;
      fm_meta_q <= 1'b1;
      fm_s_q    <= 1'b1;
      fm_prev_q <= 1'b1;
      mute_q    <= 1'b1;
      state_q   <= UNLOCKED;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      ref_h_q   <= '0;
      ref_v_q   <= '0;
      match_q   <= '0;
    end else begin
      vs1_q     <= VSYNC_i;
      hs1_q     <= HSYNC_i;
      de1_q     <= DE_i;
      vd1_q     <= VD_i;
      vs_prev_q <= vs1_q;
      hs_prev_q <= hs1_q;
      vs_o_q    <= vs1_q;
      hs_o_q    <= hs1_q;
      de_o_q    <= de1_q;
      vd_o_q    <= mute_q ? '0 : vd1_q;
      fm_meta_q <= force_mute_i;
      fm_s_q    <= fm_meta_q;
      fm_prev_q <= fm_s_q;
      mute_q    <= mute_d;
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      ref_h_q   <= ref_h_d;
      ref_v_q   <= ref_v_d;
      match_q   <= match_d;
    end
  end

  assign VSYNC_o  = vs_o_q;
  assign HSYNC_o  = hs_o_q;
  assign DE_o     = de_o_q;
  assign VD_o     = vd_o_q;
  assign locked_o = (state_q == LOCKED);

`ifdef VOUT_GUARD_STATS_EN
  logic [11:0] h_tot_q, v_tot_q;
  logic [7:0]  unl_q;
  logic        unlock_evt;

  assign unlock_evt = (state_q == LOCKED) && (state_d != LOCKED);

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      h_tot_q <= '0;
      v_tot_q <= '0;
      unl_q   <= '0;
    end else begin
      if (vs_rise) begin
        h_tot_q <= ref_h_d;
        v_tot_q <= ref_v_d;
      end
      if (unlock_evt && !(&unl_q)) unl_q <= unl_q + 8'd1;
    end
  end

  assign h_total_o    = h_tot_q;
  assign v_total_o    = v_tot_q;
  assign unlock_cnt_o = unl_q;
`else
  assign h_total_o    = '0;
  assign v_total_o    = '0;
  assign unlock_cnt_o = '0;
`endif

endmodule
